// File: rtl/matrix_gen_pkg.sv
// Shared types and constants for the multi-matrix generation handler.
package matrix_gen_pkg;

  typedef enum logic [1:0] {
    MODE_RANDOM   = 2'd0,
    MODE_ZERO     = 2'd1,
    MODE_IDENTITY = 2'd2,
    MODE_CONST    = 2'd3
  } gen_mode_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_COUNT  = 3'd1,
    ERR_DIM    = 3'd2,
    ERR_MODE   = 3'd3,
    ERR_RANGE  = 3'd4,
    ERR_SLOTS  = 3'd5,
    ERR_SQUARE = 3'd6
  } gen_err_e;

  // Controller states, kept as plain constants for legacy compatibility.
  typedef logic [3:0] gen_state_t;
  localparam gen_state_t ST_IDLE      = 4'd0;
  localparam gen_state_t ST_RD_HDR    = 4'd1;
  localparam gen_state_t ST_VALIDATE  = 4'd2;
  localparam gen_state_t ST_SCAN      = 4'd3;
  localparam gen_state_t ST_REQ       = 4'd4;
  localparam gen_state_t ST_STREAM    = 4'd5;
  localparam gen_state_t ST_WAIT_DONE = 4'd6;
  localparam gen_state_t ST_DONE      = 4'd7;
  localparam gen_state_t ST_ERROR     = 4'd8;

  // Galois LFSR polynomial x^32 + x^22 + x^2 + x + 1, right-shifting form.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2024;
  // Slot header occupancy field.
  localparam logic [31:0] OCC_MASK  = 32'h0000_00FF;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // ASCII "GEN_xx  " with xx the two-digit decimal index.
  function automatic logic [63:0] gen_name(input logic [7:0] idx);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = 8'h30 + (idx / 8'd10);
    ones = 8'h30 + (idx % 8'd10);
    return {8'h47, 8'h45, 8'h4E, 8'h5F, tens, ones, 8'h20, 8'h20};
  endfunction

endpackage

// File: rtl/matrix_gen_handler_multi_value.sv
// gen_value_unit: LFSR state plus per-mode element value, combinational on current LFSR.
module gen_value_unit
  import matrix_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seed_load,
  input  logic [31:0]           seed,
  input  logic                  advance,
  input  gen_mode_e             mode,
  input  logic [7:0]            row,
  input  logic [7:0]            col,
  input  logic [31:0]           const_val,
  input  logic [31:0]           min_val,
  input  logic [32:0]           range,
  output logic [DATA_WIDTH-1:0] value
);

  logic [31:0] lfsr_q;
  logic [48:0] prod;
  logic [32:0] scaled;
  logic [33:0] rand_sum;

  // LFSR: reseed on request, otherwise step once per random element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (seed_load) begin
      lfsr_q <= (seed == 32'h0) ? 32'h1 : seed;
    end else if (advance) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // Scale the low 16 LFSR bits into [min, min+range-1]; 33-bit range admits the full span.
  assign prod     = 49'(lfsr_q[15:0]) * 49'(range);
  assign scaled   = 33'(prod >> 16);
  assign rand_sum = {{2{min_val[31]}}, min_val} + {1'b0, scaled};

  // Per-mode element value.
  always_comb begin
    value = '0;
    unique case (mode)
      MODE_RANDOM:   value = DATA_WIDTH'(rand_sum);
      MODE_ZERO:     value = '0;
      MODE_IDENTITY: value = (row == col) ? DATA_WIDTH'(1) : '0;
      MODE_CONST:    value = DATA_WIDTH'(const_val);
      default:       value = '0;
    endcase
  end

endmodule

// File: rtl/matrix_gen_handler_multi.sv
// Multi-matrix generation handler: reads a request, validates it, finds free slots and
// streams COUNT generated matrices to the writer.
// Optional: GEN_SEED_PORT_EN adds a seed input loaded on every accepted start.
module matrix_gen_handler_multi
  import matrix_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_DIM    = 32,
  parameter int unsigned MAX_COUNT  = 4,
  parameter int unsigned NUM_SLOTS  = 8,
  parameter int unsigned SLOT_WORDS = 1024,
  parameter int unsigned BUF_AW     = 11,
  parameter int unsigned STOR_AW    = 14
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef GEN_SEED_PORT_EN
  input  logic [31:0]                  seed,
`endif
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [2:0]                   error_code,
  input  logic [31:0]                  settings_max_row,
  input  logic [31:0]                  settings_max_col,
  input  logic [31:0]                  settings_data_min,
  input  logic [31:0]                  settings_data_max,
  output logic [BUF_AW-1:0]            buf_rd_addr,
  input  logic [31:0]                  buf_rd_data,
  output logic                         write_request,
  input  logic                         write_ready,
  output logic [$clog2(NUM_SLOTS)-1:0] matrix_id,
  output logic [7:0]                   actual_rows,
  output logic [7:0]                   actual_cols,
  output logic [63:0]                  matrix_name,
  output logic [DATA_WIDTH-1:0]        data_in,
  output logic                         data_valid,
  input  logic                         writer_ready,
  input  logic                         write_done,
  output logic [STOR_AW-1:0]           storage_rd_addr,
  input  logic [31:0]                  storage_rd_data
);

  localparam int unsigned SW    = $clog2(NUM_SLOTS);
  localparam int unsigned CW    = $clog2(MAX_COUNT + 1);
  localparam int unsigned CNT_W = ($clog2(NUM_SLOTS + 1) > 3) ? $clog2(NUM_SLOTS + 1) : 3;

  gen_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, free_cnt_q, free_cnt_d;
  logic [31:0]       word_m_q, word_m_d, word_n_q, word_n_d, word_count_q, word_count_d;
  logic [31:0]       word_mode_q, word_mode_d, word_const_q, word_const_d, min_q, min_d;
  logic [32:0]       range_q, range_d, range_c;
  logic [SW-1:0]     free_q [NUM_SLOTS];
  logic [SW-1:0]     free_d [NUM_SLOTS];
  logic [CW-1:0]     idx_q, idx_d, req_idx;
  logic [7:0]        row_q, row_d, col_q, col_d, nrow, ncol;
  logic              busy_d, done_d, error_d, write_request_d, data_valid_d;
  logic [2:0]        error_code_d, val_err;
  logic [BUF_AW-1:0] buf_rd_addr_d;
  logic [STOR_AW-1:0] storage_rd_addr_d;
  logic [SW-1:0]     matrix_id_d;
  logic [7:0]        actual_rows_d, actual_cols_d;
  logic [63:0]       matrix_name_d;
  logic [DATA_WIDTH-1:0] data_in_d, gen_value;
  logic [31:0]       lim_row, lim_col, seed_val;
  logic              do_accept, enter_req, load_elem, last_elem, slot_empty;

`ifdef GEN_SEED_PORT_EN
  assign seed_val = seed;
`else
  assign seed_val = LFSR_SEED;
`endif

  gen_value_unit #(.DATA_WIDTH(DATA_WIDTH)) u_value (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef GEN_SEED_PORT_EN
    .seed_load (do_accept),
`else
    .seed_load (1'b0),
`endif
    .seed      (seed_val),
    .advance   (load_elem && (word_mode_q[1:0] == MODE_RANDOM)),
    .mode      (gen_mode_e'(word_mode_q[1:0])),
    .row       (nrow),
    .col       (ncol),
    .const_val (word_const_q),
    .min_val   (min_q),
    .range     (range_q),
    .value     (gen_value)
  );

  // Request validation; first failing check wins.
  always_comb begin
    lim_row = (settings_max_row < MAX_DIM) ? settings_max_row : MAX_DIM;
    lim_col = (settings_max_col < MAX_DIM) ? settings_max_col : MAX_DIM;
    range_c = {settings_data_max[31], settings_data_max}
            - {settings_data_min[31], settings_data_min} + 33'd1;
    val_err = ERR_NONE;
    if (word_count_q == 32'd0 || word_count_q > MAX_COUNT)
      val_err = ERR_COUNT;
    else if (word_m_q == 32'd0 || word_n_q == 32'd0 || word_m_q > lim_row || word_n_q > lim_col)
      val_err = ERR_DIM;
    else if (word_mode_q > 32'd3)
      val_err = ERR_MODE;
    else if (word_mode_q == 32'd0 && $signed(settings_data_min) > $signed(settings_data_max))
      val_err = ERR_RANGE;
    else if (word_mode_q == 32'd2 && word_m_q != word_n_q)
      val_err = ERR_SQUARE;
  end

  // Row-major lookahead position of the element about to be loaded into data_in.
  always_comb begin
    nrow = row_q;
    ncol = col_q + 8'd1;
    if (state_q == ST_REQ) begin
      nrow = '0;
      ncol = '0;
    end else if (col_q == 8'(word_n_q - 32'd1)) begin
      nrow = row_q + 8'd1;
      ncol = '0;
    end
  end

  assign last_elem  = (row_q == 8'(word_m_q - 32'd1)) && (col_q == 8'(word_n_q - 32'd1));
  assign slot_empty = (storage_rd_data & OCC_MASK) == 32'h0;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;  cnt_d = cnt_q;  free_cnt_d = free_cnt_q;  free_d = free_q;
    word_m_d = word_m_q;  word_n_d = word_n_q;  word_count_d = word_count_q;
    word_mode_d = word_mode_q;  word_const_d = word_const_q;
    min_d = min_q;  range_d = range_q;  idx_d = idx_q;  row_d = row_q;  col_d = col_q;
    done_d = 1'b0;  error_d = error;  error_code_d = error_code;
    buf_rd_addr_d = buf_rd_addr;  storage_rd_addr_d = storage_rd_addr;
    write_request_d = write_request;  matrix_id_d = matrix_id;
    actual_rows_d = actual_rows;  actual_cols_d = actual_cols;  matrix_name_d = matrix_name;
    data_in_d = data_in;  data_valid_d = data_valid;
    do_accept = 1'b0;  enter_req = 1'b0;  load_elem = 1'b0;  req_idx = '0;

    case (state_q)
      ST_IDLE:  if (start) do_accept = 1'b1;
      ST_ERROR: if (start) do_accept = 1'b1;
      ST_RD_HDR: begin
        cnt_d = cnt_q + 1'b1;
        buf_rd_addr_d = (cnt_q < CNT_W'(4)) ? BUF_AW'(cnt_q + 1'b1) : '0;
        if (cnt_q == CNT_W'(1)) word_m_d     = buf_rd_data;
        if (cnt_q == CNT_W'(2)) word_n_d     = buf_rd_data;
        if (cnt_q == CNT_W'(3)) word_count_d = buf_rd_data;
        if (cnt_q == CNT_W'(4)) word_mode_d  = buf_rd_data;
        if (cnt_q == CNT_W'(5)) begin
          word_const_d = buf_rd_data;
          state_d      = ST_VALIDATE;
        end
      end
      ST_VALIDATE: begin
        min_d   = settings_data_min;
        range_d = range_c;
        if (val_err != ERR_NONE) begin
          state_d = ST_ERROR;  error_d = 1'b1;  error_code_d = val_err;
        end else begin
          state_d = ST_SCAN;  cnt_d = '0;  free_cnt_d = '0;  storage_rd_addr_d = '0;
        end
      end
      ST_SCAN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q != '0 && slot_empty) begin
          free_d[free_cnt_q[SW-1:0]] = SW'(cnt_q - 1'b1);
          free_cnt_d = free_cnt_q + 1'b1;
        end
        if (cnt_q == CNT_W'(NUM_SLOTS)) begin
          storage_rd_addr_d = '0;
          if (32'(free_cnt_d) < word_count_q) begin
            state_d = ST_ERROR;  error_d = 1'b1;  error_code_d = ERR_SLOTS;
          end else begin
            enter_req = 1'b1;  idx_d = '0;
          end
        end else begin
          storage_rd_addr_d = STOR_AW'(32'(cnt_q + 1'b1) * SLOT_WORDS);
        end
      end
      ST_REQ: if (!write_ready) begin
        write_request_d = 1'b0;  data_valid_d = 1'b1;  load_elem = 1'b1;  state_d = ST_STREAM;
      end
      ST_STREAM: if (writer_ready) begin
        if (last_elem) begin
          data_valid_d = 1'b0;  state_d = ST_WAIT_DONE;
        end else begin
          load_elem = 1'b1;
        end
      end
      ST_WAIT_DONE: if (write_done) begin
        idx_d = idx_q + 1'b1;
        if (32'(idx_d) == word_count_q) begin
          state_d = ST_DONE;  done_d = 1'b1;
        end else begin
          enter_req = 1'b1;  req_idx = idx_d;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (do_accept) begin
      state_d = ST_RD_HDR;  cnt_d = '0;  buf_rd_addr_d = '0;  error_d = 1'b0;  error_code_d = ERR_NONE;
    end
    if (enter_req) begin
      state_d = ST_REQ;  write_request_d = 1'b1;  matrix_id_d = free_d[SW'(req_idx)];
      actual_rows_d = word_m_q[7:0];  actual_cols_d = word_n_q[7:0];
      matrix_name_d = gen_name(8'(req_idx));  row_d = '0;  col_d = '0;
    end
    if (load_elem) begin
      data_in_d = gen_value;  row_d = nrow;  col_d = ncol;
    end
    busy_d = !(state_d == ST_IDLE || state_d == ST_DONE || state_d == ST_ERROR);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;  cnt_q <= '0;  free_cnt_q <= '0;  free_q <= '{default: '0};
      word_m_q <= '0;  word_n_q <= '0;  word_count_q <= '0;  word_mode_q <= '0;  word_const_q <= '0;
      min_q <= '0;  range_q <= '0;  idx_q <= '0;  row_q <= '0;  col_q <= '0;
      busy <= 1'b0;  done <= 1'b0;  error <= 1'b0;  error_code <= '0;
      buf_rd_addr <= '0;  storage_rd_addr <= '0;  write_request <= 1'b0;  matrix_id <= '0;
      actual_rows <= '0;  actual_cols <= '0;  matrix_name <= '0;  data_in <= '0;  data_valid <= 1'b0;
    end else begin
      state_q <= state_d;  cnt_q <= cnt_d;  free_cnt_q <= free_cnt_d;  free_q <= free_d;
      word_m_q <= word_m_d;  word_n_q <= word_n_d;  word_count_q <= word_count_d;
      word_mode_q <= word_mode_d;  word_const_q <= word_const_d;
      min_q <= min_d;  range_q <= range_d;  idx_q <= idx_d;  row_q <= row_d;  col_q <= col_d;
      busy <= busy_d;  done <= done_d;  error <= error_d;  error_code <= error_code_d;
      buf_rd_addr <= buf_rd_addr_d;  storage_rd_addr <= storage_rd_addr_d;
      write_request <= write_request_d;  matrix_id <= matrix_id_d;
      actual_rows <= actual_rows_d;  actual_cols <= actual_cols_d;  matrix_name <= matrix_name_d;
      data_in <= data_in_d;  data_valid <= data_valid_d;
    end
  end

endmodule

// File: tb/tb_matrix_gen_handler_multi.sv
// Bench for matrix_gen_handler_multi: buffer/storage models, reactive writer, scoreboard queues.
module tb_matrix_gen_handler_multi;

  logic        clk, rst_n, start;
  logic        busy, done, error;
  logic [2:0]  error_code;
  logic [31:0] settings_max_row, settings_max_col, settings_data_min, settings_data_max;
  logic [10:0] buf_rd_addr;
  logic [31:0] buf_rd_data;
  logic        write_request, write_ready;
  logic [2:0]  matrix_id;
  logic [7:0]  actual_rows, actual_cols;
  logic [63:0] matrix_name;
  logic [31:0] data_in;
  logic        data_valid, writer_ready, write_done;
  logic [13:0] storage_rd_addr;
  logic [31:0] storage_rd_data;
`ifdef GEN_SEED_PORT_EN
  logic [31:0] seed;
`endif

  matrix_gen_handler_multi dut (
    .clk(clk), .rst_n(rst_n),
`ifdef GEN_SEED_PORT_EN
    .seed(seed),
`endif
    .start(start), .busy(busy), .done(done), .error(error), .error_code(error_code),
    .settings_max_row(settings_max_row), .settings_max_col(settings_max_col),
    .settings_data_min(settings_data_min), .settings_data_max(settings_data_max),
    .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
    .write_request(write_request), .write_ready(write_ready), .matrix_id(matrix_id),
    .actual_rows(actual_rows), .actual_cols(actual_cols), .matrix_name(matrix_name),
    .data_in(data_in), .data_valid(data_valid), .writer_ready(writer_ready),
    .write_done(write_done), .storage_rd_addr(storage_rd_addr), .storage_rd_data(storage_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    int          rows;
    int          cols;
    logic [63:0] name;
  } hdr_t;

  logic [31:0] bufmem [5];
  bit          occ [8];
  hdr_t        hdr_q [$];
  logic [31:0] elem_q [$];
  hdr_t        cur;
  logic [31:0] lfsr_m, held;
  int          n_checks = 0, n_fail = 0;
  int          wst, xfers, n_req, n_done;
  bit          stall_mode, tog, holding, rdy;

  // Registered-read buffer and storage header models.
  always @(posedge clk) begin
    buf_rd_data <= (buf_rd_addr < 11'd5) ? bufmem[buf_rd_addr[2:0]] : 32'h0;
    if (storage_rd_addr[9:0] == 10'd0 && storage_rd_addr[13:10] < 4'd8)
      storage_rd_data <= occ[storage_rd_addr[12:10]] ? 32'h0000_0101 : 32'hFFFF_FF00;
    else
      storage_rd_data <= 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] step_model(input logic [31:0] l);
    return l[0] ? ({1'b0, l[31:1]} ^ 32'h8020_0003) : {1'b0, l[31:1]};
  endfunction

  function automatic logic [31:0] rand_model(input logic [31:0] l, input logic [31:0] mn,
                                             input logic [31:0] mx);
    longint rng, scaled;
    rng    = longint'($signed(mx)) - longint'($signed(mn)) + 64'sd1;
    scaled = (longint'(l[15:0]) * rng) >>> 16;
    return 32'(longint'($signed(mn)) + scaled);
  endfunction

  // Reactive writer and output monitor, all on the falling edge.
  initial begin
    wst = 0; xfers = 0; n_req = 0; n_done = 0; tog = 1'b0; holding = 1'b0;
    write_ready = 1'b1; writer_ready = 1'b0; write_done = 1'b0;
    forever @(negedge clk) begin
      if (!rst_n) begin
        write_ready = 1'b1; writer_ready = 1'b0; write_done = 1'b0; wst = 0; holding = 1'b0;
      end else begin
        if (done) n_done++;
        if (wst == 0) begin
          write_done = 1'b0;
          if (write_request) begin
            n_req++;
            if (hdr_q.size() == 0) check("unexpected_request", 64'd1, 64'd0);
            else begin
              cur = hdr_q.pop_front();
              check("matrix_id", 64'(matrix_id), 64'(cur.slot));
              check("actual_rows", 64'(actual_rows), 64'(cur.rows));
              check("actual_cols", 64'(actual_cols), 64'(cur.cols));
              check("matrix_name", matrix_name, cur.name);
            end
            write_ready = 1'b0; xfers = 0; wst = 1;
          end
        end else if (data_valid) begin
          if (holding) begin
            check("stall_hold", 64'(data_in), 64'(held));
            holding = 1'b0;
          end
          rdy = stall_mode ? tog : 1'b1;
          tog = ~tog;
          writer_ready = rdy;
          if (rdy) begin
            xfers++;
            if (elem_q.size() == 0) check("unexpected_element", 64'd1, 64'd0);
            else check("data_in", 64'(data_in), 64'(elem_q.pop_front()));
          end else begin
            held = data_in; holding = 1'b1;
          end
        end else if (xfers > 0) begin
          writer_ready = 1'b0;
          check("xfer_count", 64'(xfers), 64'(cur.rows * cur.cols));
          write_done = 1'b1; write_ready = 1'b1; wst = 0;
        end
      end
    end
  end

  task automatic push_expect(input int m, input int n, input int cnt, input int mode,
                             input logic [31:0] cval);
    int fs [$];
    hdr_t h;
    for (int s = 0; s < 8; s++) if (!occ[s]) fs.push_back(s);
    for (int k = 0; k < cnt; k++) begin
      h.slot = fs[k]; h.rows = m; h.cols = n;
      h.name = {"GEN_", 8'(48 + k / 10), 8'(48 + k % 10), 16'h2020};
      hdr_q.push_back(h);
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) begin
          case (mode)
            0: begin
              elem_q.push_back(rand_model(lfsr_m, settings_data_min, settings_data_max));
              lfsr_m = step_model(lfsr_m);
            end
            1: elem_q.push_back(32'h0);
            2: elem_q.push_back((r == c) ? 32'h1 : 32'h0);
            default: elem_q.push_back(cval);
          endcase
        end
    end
  endtask

  task automatic run_req(input string tag, input int m, input int n, input int cnt,
                         input int mode, input logic [31:0] cval, input int exp_err);
    int req0, done0;
    bufmem[0] = 32'(m); bufmem[1] = 32'(n); bufmem[2] = 32'(cnt);
    bufmem[3] = 32'(mode); bufmem[4] = cval;
`ifdef GEN_SEED_PORT_EN
    lfsr_m = (seed == 32'h0) ? 32'h1 : seed;
`endif
    if (exp_err == 0) push_expect(m, n, cnt, mode, cval);
    req0 = n_req; done0 = n_done;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check({tag, "_busy_after_start"}, 64'(busy), 64'd1);
    check({tag, "_error_cleared"}, 64'(error), 64'd0);
    for (int i = 0; i < 3000; i++) begin
      if (done || error) break;
      @(negedge clk);
    end
    if (exp_err == 0) begin
      check({tag, "_done"}, 64'(done), 64'd1);
      check({tag, "_no_error"}, 64'(error), 64'd0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_done_pulses"}, 64'(n_done - done0), 64'd1);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_elems_left"}, 64'(elem_q.size()), 64'd0);
      check({tag, "_hdrs_left"}, 64'(hdr_q.size()), 64'd0);
    end else begin
      check({tag, "_error"}, 64'(error), 64'd1);
      check({tag, "_error_code"}, 64'(error_code), 64'(exp_err));
      check({tag, "_no_write_request"}, 64'(n_req - req0), 64'd0);
      @(negedge clk);
      check({tag, "_error_held"}, 64'(error), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({busy, done, error, error_code, write_request, data_valid}), 64'd0);
    check({tag, "_addr"}, 64'({buf_rd_addr, storage_rd_addr, matrix_id}), 64'd0);
    check({tag, "_dims"}, 64'({actual_rows, actual_cols, data_in}), 64'd0);
    check({tag, "_name"}, matrix_name, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall_mode = 1'b0;
    settings_max_row = 32'd32; settings_max_col = 32'd32;
    settings_data_min = -32'sd100; settings_data_max = 32'sd100;
    for (int i = 0; i < 5; i++) bufmem[i] = 32'h0;
    for (int s = 0; s < 8; s++) occ[s] = 1'b0;
`ifdef GEN_SEED_PORT_EN
    seed = 32'h1357_9BDF;
`endif
    lfsr_m = 32'hACE1_2024;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    run_req("rand2x3", 2, 3, 2, 0, 32'h0, 0);

    occ[0] = 1'b1; occ[2] = 1'b1;
    run_req("ident3x3", 3, 3, 1, 2, 32'h0, 0);

    occ[0] = 1'b0; occ[2] = 1'b0;
    run_req("bad_count", 2, 2, 5, 1, 32'h0, 1);
    run_req("bad_dim", 33, 2, 1, 1, 32'h0, 2);
    run_req("bad_mode", 2, 2, 1, 4, 32'h0, 3);
    settings_data_min = 32'sd50; settings_data_max = -32'sd50;
    run_req("min_gt_max", 2, 2, 1, 0, 32'h0, 4);
    settings_data_min = -32'sd100; settings_data_max = 32'sd100;
    run_req("ident_nonsq", 2, 3, 1, 2, 32'h0, 6);
    for (int s = 0; s < 5; s++) occ[s] = 1'b1;
    run_req("no_slots", 2, 2, 4, 1, 32'h0, 5);
    for (int s = 0; s < 8; s++) occ[s] = 1'b0;

    stall_mode = 1'b1;
    run_req("const_stall", 3, 2, 1, 3, 32'd7, 0);
    stall_mode = 1'b0;

    // Abort mid-stream with reset, then run a fresh request.
    bufmem[0] = 32'd4; bufmem[1] = 32'd4; bufmem[2] = 32'd1; bufmem[3] = 32'd3; bufmem[4] = 32'd5;
    push_expect(4, 4, 1, 3, 32'd5);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (xfers >= 4) break;
      @(negedge clk);
    end
    check("midstream_reached", 64'(xfers >= 4), 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    hdr_q.delete(); elem_q.delete();
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    lfsr_m = 32'hACE1_2024;
    run_req("rand_after_rst", 2, 2, 1, 0, 32'h0, 0);

    settings_data_min = 32'h8000_0000; settings_data_max = 32'h7FFF_FFFF;
    run_req("rand_fullspan", 2, 2, 1, 0, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
